// File: rtl/hazard_pkg.sv
// Shared definitions for the issue-control hazard logic: FSM encoding,
// scoreboard geometry and the {is_vector, reg} index helper.
package hazard_pkg;
  localparam int SB_W  = 64;
  localparam int IDX_W = 6;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] sb_idx(input logic is_vec, input logic [4:0] sel);
    return {is_vec, sel};
  endfunction
endpackage

// File: rtl/scoreboard.sv
// 64-bit pending-writeback scoreboard: one set port, one clear port,
// four source lookups and one destination lookup against the registered bits.
module scoreboard
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set_en,
  input  logic [IDX_W-1:0]      i_set_idx,
  input  logic                  i_clr_en,
  input  logic [IDX_W-1:0]      i_clr_idx,
  input  logic [3:0][IDX_W-1:0] i_src_idx,
  input  logic [IDX_W-1:0]      i_dst_idx,
  output logic [3:0]            o_src_hit,
  output logic                  o_dst_hit
);
  logic [SB_W-1:0] r_bits;

  // Set and clear never target the same bit in one cycle (WAW holds the setter).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bits <= '0;
    end else begin
      if (i_clr_en) r_bits[i_clr_idx] <= 1'b0;
      if (i_set_en) r_bits[i_set_idx] <= 1'b1;
    end
  end

  always_comb begin
    o_src_hit = '0;
    for (int i = 0; i < 4; i++) o_src_hit[i] = r_bits[i_src_idx[i]];
  end

  assign o_dst_hit = r_bits[i_dst_idx];
endmodule

// File: rtl/hazard_controller.sv
// Fetch/decode issue control: RAW/WAW stalls against outstanding loads,
// load-capacity limiting, and the rollback flush sequencer.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MAX_PENDING  = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid_i,
  input  logic [4:0] scalar_sel1_i,
  input  logic [4:0] scalar_sel2_i,
  input  logic [4:0] vector_sel1_i,
  input  logic [4:0] vector_sel2_i,
  input  logic       uses_s1_i,
  input  logic       uses_s2_i,
  input  logic       uses_v1_i,
  input  logic       uses_v2_i,
  input  logic       has_writeback_i,
  input  logic [4:0] writeback_reg_i,
  input  logic       writeback_is_vector_i,
  input  logic       is_load_i,
  input  logic       load_done_i,
  input  logic [4:0] load_done_reg_i,
  input  logic       load_done_is_vector_i,
  input  logic       rollback_i,
  output logic       stall_o,
  output logic       issue_o,
  output logic       flush_o,
  output logic [3:0] pending_count_o
);
  localparam logic [3:0] MAX_CNT    = 4'(MAX_PENDING);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t                r_state;
  logic [2:0]            r_flush_cnt;
  logic [3:0]            r_count;

  logic [3:0][IDX_W-1:0] w_src_idx;
  logic [3:0]            w_src_hit;
  logic                  w_dst_hit;
  logic                  w_raw;
  logic                  w_waw;
  logic                  w_cap;
  logic                  w_run;
  logic                  w_set;
  logic                  w_clr;

  assign w_src_idx = {sb_idx(1'b1, vector_sel2_i), sb_idx(1'b1, vector_sel1_i),
                      sb_idx(1'b0, scalar_sel2_i), sb_idx(1'b0, scalar_sel1_i)};

  scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_set_en  (w_set),
    .i_set_idx (sb_idx(writeback_is_vector_i, writeback_reg_i)),
    .i_clr_en  (w_clr),
    .i_clr_idx (sb_idx(load_done_is_vector_i, load_done_reg_i)),
    .i_src_idx (w_src_idx),
    .i_dst_idx (sb_idx(writeback_is_vector_i, writeback_reg_i)),
    .o_src_hit (w_src_hit),
    .o_dst_hit (w_dst_hit)
  );

  assign w_raw   = |(w_src_hit & {uses_v2_i, uses_v1_i, uses_s2_i, uses_s1_i});
  assign w_waw   = has_writeback_i & w_dst_hit;
  assign w_cap   = is_load_i & has_writeback_i & (r_count == MAX_CNT);
  assign w_run   = (r_state == ST_RUN);

  assign stall_o = instr_valid_i & (w_raw | w_waw | w_cap) & w_run;
  assign issue_o = instr_valid_i & ~stall_o & w_run & ~rollback_i;
  assign flush_o = rollback_i | (r_state == ST_FLUSH);
  assign pending_count_o = r_count;

  assign w_set   = issue_o & is_load_i & has_writeback_i;
  assign w_clr   = load_done_i;

  // A completion with nothing outstanding is a protocol error; hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_set && !w_clr) begin
      r_count <= r_count + 4'd1;
    end else if (w_clr && !w_set && r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  // FLUSH covers the FLUSH_CYCLES-1 cycles after the rollback cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (rollback_i && FLUSH_CYCLES > 1) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (rollback_i) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt <= 3'd1) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_flush_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table plus randomized traffic
// compared against a queue/deadline reference model.
module tb_hazard_controller;
  localparam int MAX_PENDING  = 4;
  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [4:0] scalar_sel1, scalar_sel2, vector_sel1, vector_sel2;
  logic       uses_s1, uses_s2, uses_v1, uses_v2;
  logic       has_wb;
  logic [4:0] wb_reg;
  logic       wb_vec;
  logic       is_load;
  logic       load_done;
  logic [4:0] load_done_reg;
  logic       load_done_vec;
  logic       rollback;
  logic       stall, issue, flush;
  logic [3:0] pcount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MAX_PENDING(MAX_PENDING), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .instr_valid_i         (instr_valid),
    .scalar_sel1_i         (scalar_sel1),
    .scalar_sel2_i         (scalar_sel2),
    .vector_sel1_i         (vector_sel1),
    .vector_sel2_i         (vector_sel2),
    .uses_s1_i             (uses_s1),
    .uses_s2_i             (uses_s2),
    .uses_v1_i             (uses_v1),
    .uses_v2_i             (uses_v2),
    .has_writeback_i       (has_wb),
    .writeback_reg_i       (wb_reg),
    .writeback_is_vector_i (wb_vec),
    .is_load_i             (is_load),
    .load_done_i           (load_done),
    .load_done_reg_i       (load_done_reg),
    .load_done_is_vector_i (load_done_vec),
    .rollback_i            (rollback),
    .stall_o               (stall),
    .issue_o               (issue),
    .flush_o               (flush),
    .pending_count_o       (pcount)
  );

  // Keys are 0..31 scalar, 32..63 vector; -1 means "none".
  typedef struct {
    logic rst; logic iv; int rd; int wr; logic ld; int dn; logic rb;
    logic e_st; logic e_is; logic e_fl; int e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic iv, input int rd, input int wr,
                              input logic ld, input int dn, input logic rb,
                              input logic e_st, input logic e_is, input logic e_fl, input int e_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rd = rd; v.wr = wr; v.ld = ld; v.dn = dn; v.rb = rb;
    v.e_st = e_st; v.e_is = e_is; v.e_fl = e_fl; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Unused selects carry random values so uses_* gating is exercised.
  task automatic drive_idle();
    reset = 1'b0; instr_valid = 1'b0;
    scalar_sel1 = 5'($urandom_range(0, 31)); scalar_sel2 = 5'($urandom_range(0, 31));
    vector_sel1 = 5'($urandom_range(0, 31)); vector_sel2 = 5'($urandom_range(0, 31));
    uses_s1 = 1'b0; uses_s2 = 1'b0; uses_v1 = 1'b0; uses_v2 = 1'b0;
    has_wb = 1'b0; wb_reg = '0; wb_vec = 1'b0; is_load = 1'b0;
    load_done = 1'b0; load_done_reg = '0; load_done_vec = 1'b0; rollback = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    drive_idle();
    reset = v.rst; instr_valid = v.iv; is_load = v.ld; rollback = v.rb;
    if (v.rd >= 0) begin
      if (v.rd < 32) begin scalar_sel1 = 5'(v.rd); uses_s1 = 1'b1; end
      else           begin vector_sel1 = 5'(v.rd - 32); uses_v1 = 1'b1; end
    end
    if (v.wr >= 0) begin has_wb = 1'b1; wb_reg = 5'(v.wr % 32); wb_vec = (v.wr >= 32); end
    if (v.dn >= 0) begin load_done = 1'b1; load_done_reg = 5'(v.dn % 32); load_done_vec = (v.dn >= 32); end
  endtask

  // Reference model: pending loads as a list of keys, flush as a cycle deadline.
  int pend_q[$];
  int flush_end;
  int cyc;

  function automatic bit in_q(input int key);
    foreach (pend_q[i]) if (pend_q[i] == key) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    tbl.push_back(mk(0,0,-1,-1,0,-1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1, 3,1,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1, 3,-1,0,-1,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 3,-1,0,-1,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 3,-1,0, 3,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 3,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1,37,1,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1,37,0,-1,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 5,-1,0,-1,0, 0,1,0,1));
    tbl.push_back(mk(0,1,37,-1,0,-1,0, 1,0,0,1));
    tbl.push_back(mk(0,0,-1,-1,0,37,0, 0,0,0,1));
    tbl.push_back(mk(0,0,-1,-1,0,-1,0, 0,0,0,0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0,1,-1,k,1,-1,0, 0,1,0,k-1));
    tbl.push_back(mk(0,1,-1, 6,1,-1,0, 1,0,0,4));
    tbl.push_back(mk(0,1,-1, 8,0,-1,0, 0,1,0,4));
    tbl.push_back(mk(0,0,-1,-1,0, 1,0, 0,0,0,4));
    tbl.push_back(mk(0,1,-1, 6,1, 2,0, 0,1,0,3));
    tbl.push_back(mk(0,0,-1,-1,0, 3,0, 0,0,0,3));
    tbl.push_back(mk(0,0,-1,-1,0, 4,0, 0,0,0,2));
    tbl.push_back(mk(0,0,-1,-1,0, 6,0, 0,0,0,1));
    tbl.push_back(mk(0,0,-1,-1,0,-1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,1, 0,0,1,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,1, 0,0,1,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,1, 0,0,1,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,-1,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1, 7,1,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1, 7,-1,0,-1,1, 1,0,1,1));
    tbl.push_back(mk(0,1, 7,-1,0,-1,0, 0,0,1,1));
    tbl.push_back(mk(0,1, 7,-1,0,-1,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 7,-1,0, 7,0, 1,0,0,1));
    tbl.push_back(mk(0,1, 7,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1, 1,1,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,-1, 2,1,-1,0, 0,1,0,1));
    tbl.push_back(mk(0,0,-1,-1,0,-1,1, 0,0,1,2));
    tbl.push_back(mk(1,0,-1,-1,0,-1,0, 0,0,1,2));
    tbl.push_back(mk(0,1, 1,-1,0,-1,0, 0,1,0,0));
    tbl.push_back(mk(0,0,-1,-1,0, 9,0, 0,0,0,0));
    tbl.push_back(mk(0,1, 2,-1,0,-1,0, 0,1,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #2;
      check($sformatf("row%0d_stall", i), int'(stall), int'(tbl[i].e_st));
      check($sformatf("row%0d_issue", i), int'(issue), int'(tbl[i].e_is));
      check($sformatf("row%0d_flush", i), int'(flush), int'(tbl[i].e_fl));
      check($sformatf("row%0d_count", i), int'(pcount), tbl[i].e_cnt);
    end

    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    pend_q.delete();
    cyc = 0;
    flush_end = -1;

    for (int n = 0; n < 2000; n++) begin
      int  j;
      bit  haz, cap, in_run, e_st, e_is, e_fl;
      @(negedge clk);
      drive_idle();
      reset       = ($urandom_range(0, 299) == 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      scalar_sel1 = 5'($urandom_range(0, 3)); scalar_sel2 = 5'($urandom_range(0, 3));
      vector_sel1 = 5'($urandom_range(0, 3)); vector_sel2 = 5'($urandom_range(0, 3));
      uses_s1 = 1'($urandom); uses_s2 = 1'($urandom);
      uses_v1 = 1'($urandom); uses_v2 = 1'($urandom);
      has_wb  = 1'($urandom); wb_vec = 1'($urandom);
      wb_reg  = 5'($urandom_range(0, 3));
      is_load = 1'($urandom);
      rollback = ($urandom_range(0, 19) == 0);
      j = -1;
      if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, pend_q.size() - 1);
        load_done     = 1'b1;
        load_done_reg = 5'(pend_q[j] % 32);
        load_done_vec = (pend_q[j] >= 32);
      end

      haz = (uses_s1 && in_q(int'(scalar_sel1))) || (uses_s2 && in_q(int'(scalar_sel2))) ||
            (uses_v1 && in_q(32 + int'(vector_sel1))) || (uses_v2 && in_q(32 + int'(vector_sel2))) ||
            (has_wb && in_q((wb_vec ? 32 : 0) + int'(wb_reg)));
      cap    = is_load && has_wb && (pend_q.size() == MAX_PENDING);
      in_run = !(cyc <= flush_end);
      e_st   = instr_valid && (haz || cap) && in_run;
      e_is   = instr_valid && !e_st && in_run && !rollback;
      e_fl   = rollback || !in_run;

      #2;
      check("rand_stall", int'(stall), int'(e_st));
      check("rand_issue", int'(issue), int'(e_is));
      check("rand_flush", int'(flush), int'(e_fl));
      check("rand_count", int'(pcount), pend_q.size());

      if (reset) begin
        pend_q.delete();
        flush_end = cyc;
      end else begin
        if (j >= 0) pend_q.delete(j);
        if (e_is && is_load && has_wb) pend_q.push_back((wb_vec ? 32 : 0) + int'(wb_reg));
        if (rollback) flush_end = cyc + FLUSH_CYCLES - 1;
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Issue-control block between fetch and decode. Keeps a 64-entry scoreboard of registers with outstanding long-latency (load) writebacks, holds fetch/decode on RAW or WAW hazards against those registers, and limits the number of loads in flight. On a rollback from execute it sequences the `flush_i` pulse train into the decode stage.

## Interface
Parameters:
- MAX_PENDING, 4: maximum outstanding loads (1..15).
- FLUSH_CYCLES, 2: number of consecutive cycles `flush_o` is high per rollback (1..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid_i  in  1  a decodable instruction is present at decode input.
- scalar_sel1_i, scalar_sel2_i  in  5 each  scalar source selects, same values decode drives to the register file.
- vector_sel1_i, vector_sel2_i  in  5 each  vector source selects.
- uses_s1_i, uses_s2_i, uses_v1_i, uses_v2_i  in  1 each  the corresponding source is actually read.
- has_writeback_i  in  1  the instruction writes a register.
- writeback_reg_i  in  5  destination register.
- writeback_is_vector_i  in  1  destination is a vector register.
- is_load_i  in  1  the instruction is a memory load (long latency).
- load_done_i  in  1  a load result is being written back this cycle.
- load_done_reg_i  in  5  register of the completing load.
- load_done_is_vector_i  in  1  completing load targets a vector register.
- rollback_i  in  1  execute redirects the PC; younger instructions are invalid.
- stall_o  out  1  hold PC and the decode input register.
- issue_o  out  1  the instruction advances into decode this cycle.
- flush_o  out  1  drives decode `flush_i`.
- pending_count_o  out  4  number of outstanding loads.

## Operation
- Scoreboard index is {is_vector, reg}: bits 0..31 are scalar, bits 32..63 are vector.
- Hazard is 1 when any used source has its bit set (RAW), or when `has_writeback_i` is high and the destination bit is set (WAW).
- Capacity stall: `is_load_i & has_writeback_i & (pending_count == MAX_PENDING)`.
- `stall_o = instr_valid_i & (hazard | capacity stall) & state==RUN`.
- `issue_o = instr_valid_i & ~stall_o & state==RUN & ~rollback_i`.
- Set: when `issue_o & is_load_i & has_writeback_i`, set the destination bit and increment the count.
- Clear: when `load_done_i`, clear the completing register's bit and decrement the count.
  - Set and clear in the same cycle leave the count unchanged.
  - The same bit cannot be both set and cleared in one cycle, because WAW stalls it.
  - A `load_done_i` for a bit that is already clear is a protocol error. The bit stays clear and the count saturates at 0.
- No clear bypass. Hazard logic reads the registered scoreboard, so a stalled instruction issues one cycle after its load completes.
- FSM states:
  - RUN: on `rollback_i`, go to FLUSH and load the counter with FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in RUN.
  - FLUSH: while the counter is nonzero, decrement it. Return to RUN when it reaches 0. A `rollback_i` in FLUSH reloads the counter.
- `flush_o = rollback_i | state==FLUSH`.
- Rollback does not alter the scoreboard or the count, because in-flight loads still complete.

## Timing
- All outputs are combinational from the registered state plus the current inputs. There are no internal registered outputs.
- Reset values (cycle after reset is sampled):
  - scoreboard = 0, count = 0, state = RUN.
  - `flush_o` = `rollback_i`, `stall_o` = 0 for any instruction, `issue_o` = `instr_valid_i`.
- Set and clear take effect at the next rising edge.
- Flush length: a rollback at cycle N drives `flush_o` high for cycles N..N+FLUSH_CYCLES-1, and `issue_o`=0 throughout.
- Reset has priority over every other input, including a rollback mid-flush.

## Structure
- Shared package `hazard_pkg` holds:
  - the FSM state encoding (RUN, FLUSH);
  - scoreboard width 64;
  - the index helper {is_vector, reg}.
- Sub-module `scoreboard`: 64-bit register with one set port, one clear port, and four source lookups plus one destination lookup.
- `hazard_controller` owns the count, the FSM and the output logic.

## Test plan
- Load to s3 issues. Next instruction reads s3 → `stall_o`=1 until `load_done_i` for s3 at cycle K. `issue_o`=1 at K+1, count returns 0.
- Load to v5 pending. Instruction writing v5 with no v5 source → stalls (WAW). A reader of s5 → no stall (scalar and vector index separation).
- MAX_PENDING=4: four loads to s1..s4 issue, count=4. A fifth load stalls. A non-load ALU op with no hazards issues. A completion in the same cycle as a new load issue keeps count=4.
- FLUSH_CYCLES=2: `rollback_i` at cycle 10 → `flush_o` high at 10 and 11, `issue_o`=0 at 10 and 11, resumes at 12. A second rollback at 11 extends `flush_o` through 12.
- Load to s7 issued, then rollback → bit s7 remains set, and the post-flush reader of s7 stalls until completion.
- Assert reset during FLUSH with two loads pending → next cycle state RUN, count 0, scoreboard clear. Spurious `load_done_i` keeps count at 0.
